// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display path:
// scan FSM states, "all off" patterns and the active-low hex glyph table.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Segment order {g,f,e,d,c,b,a}, 0 = lit; lowercase glyphs for b and d
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_if.sv
// Display-side bundle of the scanner: frame content and controls in,
// anode/segment pins and the frame strobe out.
interface seg7_scan_if;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic        lz_suppress;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output en, value, dp_in, blink_mask, lz_suppress,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  en, value, dp_in, blink_mask, lz_suppress,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern, shared by every
// display path that needs hex glyphs.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner. segclk/sltclk from the divider are
// only sampled as enables; each digit is preceded by an all-off blank interval.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int GHOST_CYCLES = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       segclk,
  input  logic       sltclk,
  seg7_scan_if.slave disp
);

  localparam logic [13:0] GHOST_LAST = 14'(GHOST_CYCLES - 1);

  logic [SYNC_STAGES-1:0] seg_sync_reg;
  logic [SYNC_STAGES-1:0] slt_sync_reg;
  logic                   seg_prev_reg;
  logic                   tick;
  logic                   blink_on;

  state_t      state_reg;
  logic [1:0]  idx_reg;
  logic [13:0] blank_cnt_reg;
  logic [15:0] value_snap_reg;
  logic [3:0]  dp_snap_reg;
  logic [3:0]  blink_snap_reg;
  logic [3:0]  an_reg;
  logic [6:0]  seg_reg;
  logic        dp_reg;
  logic        frame_done_reg;

  logic [3:0]  cur_nibble;
  logic [6:0]  hex_seg;
  logic [3:0]  zero_from;
  logic        suppress;
  logic        blanked;
  logic [3:0]  drive_an;
  logic [6:0]  drive_seg;
  logic        drive_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sync_reg <= '0;
      slt_sync_reg <= '0;
      seg_prev_reg <= 1'b0;
    end else begin
      seg_sync_reg <= {seg_sync_reg[SYNC_STAGES-2:0], segclk};
      slt_sync_reg <= {slt_sync_reg[SYNC_STAGES-2:0], sltclk};
      seg_prev_reg <= seg_sync_reg[SYNC_STAGES-1];
    end
  end

  assign tick     = seg_sync_reg[SYNC_STAGES-1] & ~seg_prev_reg;
  assign blink_on = slt_sync_reg[SYNC_STAGES-1];

  assign cur_nibble = value_snap_reg[{idx_reg, 2'b00} +: 4];

  seg7_hex_decode u_hex (
    .nibble (cur_nibble),
    .seg    (hex_seg)
  );

  // zero_from[k]: snapshot nibbles 3..k are all zero; digit 0 is never blanked
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_zero
      if (gi == 0) begin : g_first
        assign zero_from[gi] = 1'b0;
      end else begin : g_upper
        assign zero_from[gi] = ~|value_snap_reg[15:4*gi];
      end
    end
  endgenerate

  assign suppress  = disp.lz_suppress & zero_from[idx_reg];
  assign blanked   = blink_snap_reg[idx_reg] & blink_on;
  assign drive_an  = blanked ? AN_OFF : ~(4'b0001 << idx_reg);
  assign drive_seg = (blanked | suppress) ? SEG_OFF : hex_seg;
  assign drive_dp  = blanked ? 1'b1 : ~dp_snap_reg[idx_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= 2'd0;
      blank_cnt_reg  <= '0;
      value_snap_reg <= '0;
      dp_snap_reg    <= '0;
      blink_snap_reg <= '0;
      an_reg         <= AN_OFF;
      seg_reg        <= SEG_OFF;
      dp_reg         <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      an_reg         <= AN_OFF;
      seg_reg        <= SEG_OFF;
      dp_reg         <= 1'b1;
      if (!disp.en) begin
        state_reg     <= IDLE;
        idx_reg       <= 2'd0;
        blank_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            value_snap_reg <= disp.value;
            dp_snap_reg    <= disp.dp_in;
            blink_snap_reg <= disp.blink_mask;
            blank_cnt_reg  <= '0;
            state_reg      <= BLANK;
          end
          BLANK: begin
            if (blank_cnt_reg == GHOST_LAST) begin
              state_reg <= DRIVE;
              an_reg    <= drive_an;
              seg_reg   <= drive_seg;
              dp_reg    <= drive_dp;
            end else begin
              blank_cnt_reg <= blank_cnt_reg + 14'd1;
            end
          end
          DRIVE: begin
            if (tick) begin
              idx_reg       <= idx_reg + 2'd1;
              blank_cnt_reg <= '0;
              state_reg     <= BLANK;
              // Reloading only on the wrap keeps every frame consistent
              if (idx_reg == 2'd3) begin
                frame_done_reg <= 1'b1;
                value_snap_reg <= disp.value;
                dp_snap_reg    <= disp.dp_in;
                blink_snap_reg <= disp.blink_mask;
              end
            end else begin
              an_reg  <= drive_an;
              seg_reg <= drive_seg;
              dp_reg  <= drive_dp;
            end
          end
          default: begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
          end
        endcase
      end
    end
  end

  assign disp.an         = an_reg;
  assign disp.seg        = seg_reg;
  assign disp.dp         = dp_reg;
  assign disp.frame_done = frame_done_reg;

endmodule
